// File: rtl/lpddr5_rcmd_queue.sv
// lpddr5_rcmd_queue: in-order LPDDR5 read command queue.
// Issues reads in order, gathers beats per entry, returns bursts in order.
module lpddr5_rcmd_queue #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int PRIORITY_WIDTH   = 2,
  parameter int MAX_BURST_LENGTH = 16,
  parameter int DEPTH            = 8,
  localparam int TAG_WIDTH       = $clog2(DEPTH),
  localparam int BIDX_WIDTH      = $clog2(MAX_BURST_LENGTH)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                  cmd_addr,
  input  logic [PRIORITY_WIDTH-1:0]              cmd_prio,
  output logic                                   iss_valid,
  input  logic                                   iss_ready,
  output logic [ADDR_WIDTH-1:0]                  iss_addr,
  output logic [PRIORITY_WIDTH-1:0]              iss_prio,
  output logic [TAG_WIDTH-1:0]                   iss_tag,
  input  logic                                   beat_valid,
  input  logic [TAG_WIDTH-1:0]                   beat_tag,
  input  logic [BIDX_WIDTH-1:0]                  beat_idx,
  input  logic [DATA_WIDTH-1:0]                  beat_data,
  output logic                                   resp_valid,
  input  logic                                   resp_ready,
  output logic [ADDR_WIDTH-1:0]                  resp_addr,
  output logic [DATA_WIDTH*MAX_BURST_LENGTH-1:0] resp_data,
  output logic                                   beat_err,
  output logic [TAG_WIDTH:0]                     count
);

  localparam int PW = TAG_WIDTH + 1;
  localparam int BW = DATA_WIDTH * MAX_BURST_LENGTH;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  logic                        r_valid  [DEPTH];
  logic                        r_issued [DEPTH];
  logic [PRIORITY_WIDTH-1:0]   r_prio   [DEPTH];
  logic [ADDR_WIDTH-1:0]       r_addr   [DEPTH];
  logic [MAX_BURST_LENGTH-1:0] r_dv     [DEPTH];
  logic [BW-1:0]               r_rdata  [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_iss_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_beat_err;

  logic [TAG_WIDTH-1:0] w_wr_idx;
  logic [TAG_WIDTH-1:0] w_iss_idx;
  logic [TAG_WIDTH-1:0] w_rd_idx;
  logic [PW-1:0]        w_count;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_pop;
  logic                 w_beat_ok;
  logic                 w_beat_dup;
  logic                 w_beat_hit_pop;

  assign w_wr_idx  = r_wr_ptr[TAG_WIDTH-1:0];
  assign w_iss_idx = r_iss_ptr[TAG_WIDTH-1:0];
  assign w_rd_idx  = r_rd_ptr[TAG_WIDTH-1:0];
  assign w_count   = r_wr_ptr - r_rd_ptr;

  assign cmd_ready  = (w_count != FULL);
  assign iss_valid  = (r_iss_ptr != r_wr_ptr);
  assign iss_tag    = w_iss_idx;
  assign iss_addr   = r_addr[w_iss_idx];
  assign iss_prio   = r_prio[w_iss_idx];
  assign resp_valid = r_valid[w_rd_idx] && r_issued[w_rd_idx] &&
                      (&r_dv[w_rd_idx]);
  assign resp_addr  = r_addr[w_rd_idx];
  assign resp_data  = r_rdata[w_rd_idx];
  assign beat_err   = r_beat_err;
  assign count      = w_count;

  assign w_push  = cmd_valid && cmd_ready;
  assign w_issue = iss_valid && iss_ready;
  assign w_pop   = resp_valid && resp_ready;

  // Beats only land in entries the scheduler has already been given.
  assign w_beat_ok      = r_valid[beat_tag] && r_issued[beat_tag];
  assign w_beat_dup     = w_beat_ok && r_dv[beat_tag][beat_idx];
  assign w_beat_hit_pop = w_pop && (beat_tag == w_rd_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_iss_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_beat_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_issued[i] <= 1'b0;
        r_prio[i]   <= '0;
        r_addr[i]   <= '0;
        r_dv[i]     <= '0;
        r_rdata[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_valid[w_wr_idx]  <= 1'b1;
        r_issued[w_wr_idx] <= 1'b0;
        r_dv[w_wr_idx]     <= '0;
        r_addr[w_wr_idx]   <= cmd_addr;
        r_prio[w_wr_idx]   <= cmd_prio;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_issued[w_iss_idx] <= 1'b1;
        r_iss_ptr           <= r_iss_ptr + 1'b1;
      end
      if (beat_valid) begin
        if (w_beat_ok) begin
          r_rdata[beat_tag][beat_idx*DATA_WIDTH +: DATA_WIDTH] <= beat_data;
          r_dv[beat_tag][beat_idx] <= 1'b1;
        end
        if (!w_beat_ok || w_beat_dup || w_beat_hit_pop) begin
          r_beat_err <= 1'b1;
        end
      end
      // Pop is last so it wins over a same-cycle beat to the head.
      if (w_pop) begin
        r_valid[w_rd_idx]  <= 1'b0;
        r_issued[w_rd_idx] <= 1'b0;
        r_dv[w_rd_idx]     <= '0;
        r_rd_ptr           <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
